// File: rtl/cnn_pkg.sv
// Shared CNN definitions: default bus widths, conv2d_1 input geometry and
// the image-feeder state encoding.
package cnn_pkg;

   localparam int unsigned CNN_DATA_WIDTH = 16;
   localparam int unsigned CNN_ADDR_WIDTH = 16;

   localparam int unsigned CONV1_IMG_W = 28;
   localparam int unsigned CONV1_IMG_H = 28;

   typedef enum logic [1:0] {
      FEED_IDLE = 2'd0,
      FEED_LOAD = 2'd1,
      FEED_FIRE = 2'd2
   } feed_state_t;

endpackage

// File: rtl/img_feeder.sv
// Image-input write initiator: turns a valid/ready pixel stream into one frame
// of addressed writes into the CNN input buffer, then pulses work_enable.
module img_feeder
   import cnn_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = CNN_DATA_WIDTH,
   parameter int unsigned           ADDR_WIDTH = CNN_ADDR_WIDTH,
   parameter int unsigned           IMG_W      = CONV1_IMG_W,
   parameter int unsigned           IMG_H      = CONV1_IMG_H,
   parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pix_valid,
   output logic                  pix_ready,
   input  logic [DATA_WIDTH-1:0] pix_data,
   input  logic                  pix_last,
   input  logic                  img_data_wr_ready,
   output logic                  img_data_wr_en,
   output logic [ADDR_WIDTH-1:0] img_data_addr,
   output logic [DATA_WIDTH-1:0] img_data_out,
   output logic                  work_enable,
   output logic                  busy,
   output logic                  frame_err
);

   localparam int unsigned      N        = IMG_W * IMG_H;
   localparam int unsigned      CNT_W    = $clog2(N);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   feed_state_t           r_state;
   feed_state_t           w_state_nxt;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_wr_en;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_frame_err;

   logic w_pix_ready;
   logic w_work_enable;
   logic w_busy;
   logic w_accept;
   logic w_cnt_last;

   assign w_accept   = pix_valid & w_pix_ready;
   assign w_cnt_last = (r_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= FEED_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // pix_ready follows wr_ready combinationally so a falling ready blocks the
   // accept in the same cycle; FIRE always returns to IDLE first.
   always_comb begin
      w_state_nxt   = r_state;
      w_pix_ready   = 1'b0;
      w_work_enable = 1'b0;
      w_busy        = 1'b0;
      unique case (r_state)
         FEED_IDLE: begin
            if (img_data_wr_ready) w_state_nxt = FEED_LOAD;
         end
         FEED_LOAD: begin
            w_busy      = 1'b1;
            w_pix_ready = img_data_wr_ready;
            if (pix_valid && img_data_wr_ready && w_cnt_last) w_state_nxt = FEED_FIRE;
         end
         FEED_FIRE: begin
            w_busy        = 1'b1;
            w_work_enable = 1'b1;
            w_state_nxt   = FEED_IDLE;
         end
         default: w_state_nxt = FEED_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_wr_en     <= 1'b0;
         r_addr      <= '0;
         r_data      <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_wr_en     <= w_accept;
         r_frame_err <= w_accept & (pix_last ^ w_cnt_last);
         if (w_accept) begin
            r_addr <= ADDR_BASE + ADDR_WIDTH'(r_cnt);
            r_data <= pix_data;
            r_cnt  <= w_cnt_last ? '0 : r_cnt + 1'b1;
         end
      end
   end

   assign pix_ready      = w_pix_ready;
   assign img_data_wr_en = r_wr_en;
   assign img_data_addr  = r_addr;
   assign img_data_out   = r_data;
   assign work_enable    = w_work_enable;
   assign busy           = w_busy;
   assign frame_err      = r_frame_err;

endmodule

// File: doc/img_feeder.md
# img_feeder

Initiator side of the CNN image-input write port. Accepts a valid/ready pixel stream from the host/camera side, writes one full frame into the first layer's input double buffer as addressed single-word writes, then pulses `work_enable` to start the network on that frame. Sits directly in front of the CNN top-level design and drives its `img_data_wr_en`, `img_data_addr` and `img_data_in` inputs while honouring its `img_data_wr_ready` output.

## Interface
- `DATA_WIDTH`, 16: pixel word width.
- `ADDR_WIDTH`, 16: write address width.
- `IMG_W`, 28: frame width in pixels.
- `IMG_H`, 28: frame height in pixels; `N = IMG_W*IMG_H` (784).
- `ADDR_BASE`, 0: address of the first pixel.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `pix_valid` in 1: upstream pixel valid.
- `pix_ready` out 1: feeder accepts the pixel this cycle.
- `pix_data` in DATA_WIDTH: pixel value.
- `pix_last` in 1: upstream end-of-frame marker. Checked only; does not control frame length.
- `img_data_wr_ready` in 1: CNN input buffer has a free half and can take writes.
- `img_data_wr_en` out 1: write strobe to CNN.
- `img_data_addr` out ADDR_WIDTH: write address.
- `img_data_out` out DATA_WIDTH: write data; connects to the CNN `img_data_in`.
- `work_enable` out 1: one-cycle pulse after a frame is fully written.
- `busy` out 1: high in LOAD and FIRE.
- `frame_err` out 1: one-cycle pulse on a `pix_last` mismatch.

## Operation
- **State machine:** IDLE, LOAD, FIRE.
- **Pixel counter:** `cnt` runs 0..N-1 and is `$clog2(N)` bits wide.
- **IDLE:** `pix_ready` is 0.
  - Go to LOAD when `img_data_wr_ready` = 1.
- **LOAD:** `pix_ready = img_data_wr_ready` (combinational).
  - **Accept condition:** `pix_valid && pix_ready`.
  - **On accept:** register `img_data_wr_en` = 1, `img_data_addr = ADDR_BASE + cnt` (truncated to ADDR_WIDTH), `img_data_out = pix_data`.
  - **On the last pixel:** if `cnt == N-1`, clear `cnt` to 0 and go to FIRE. Otherwise `cnt` increments.
  - **Stall:** with no accept, `img_data_wr_en` = 0. Address and data hold their last values.
- **`pix_last` check:** performed on each accept.
  - `pix_last` = 1 with `cnt != N-1` is an error.
  - `pix_last` = 0 with `cnt == N-1` is an error.
  - Either error pulses `frame_err`, aligned with that pixel's write.
  - The frame still completes on the counter alone.
- **FIRE:** lasts one cycle.
  - `work_enable` = 1.
  - `pix_ready` = 0.
  - Go to IDLE.
- **Ready contract with the receiver:**
  - The CNN must deassert `img_data_wr_ready` no later than the cycle after `work_enable` if no buffer half is free.
  - The feeder never re-enters LOAD on the FIRE cycle itself.
- **Ready drop mid-frame:** `pix_ready` drops the same cycle. The write from the previous cycle's accept still issues, and the receiver must tolerate this single in-flight write. The counter and address are preserved, and the frame resumes when ready returns.

## Timing
- **Reset values:** all outputs 0 (`pix_ready`, `img_data_wr_en`, `img_data_addr`, `img_data_out`, `work_enable`, `busy`, `frame_err`); state IDLE; `cnt` 0.
- **Write latency:** a pixel accepted in cycle T appears as a write in T+1.
- **Frame latency:** the last pixel is accepted in T, written in T+1, and `work_enable` is high in T+1 (FIRE state) for exactly one cycle.
- **Throughput:**
  - One pixel per cycle while `pix_valid` and `img_data_wr_ready` are held high.
  - One idle cycle (FIRE) plus one cycle in IDLE between frames.
- **Reset mid-frame:**
  - Abandon the frame; `cnt` returns to 0 and no `work_enable` is issued.
  - Pending writes are dropped.
  - The next frame starts at `ADDR_BASE`.
- **Simultaneous events:**
  - `pix_valid` with `img_data_wr_ready` falling in the same cycle: no accept, because `pix_ready` is combinational on ready.
  - `frame_err` and `work_enable` can coincide on the last pixel.

## Structure
- **Shared package `cnn_pkg`:**
  - `DATA_WIDTH` and `ADDR_WIDTH` defaults.
  - `IMG_W` / `IMG_H` for the conv2d_1 input (28x28).
  - The feeder state enum (`FEED_IDLE`, `FEED_LOAD`, `FEED_FIRE`).
- **Sub-modules:** none required. The counter/address generator stays inline; the block is a single module.

## Test plan
1. **Basic frame:** reset, ready = 1, stream 784 pixels with values 0..783 and `pix_last` on #783 → 784 writes, addr 0..783, data equals addr, `work_enable` one pulse at the cycle of write 783, `frame_err` never.
2. **Upstream stalls:** random `pix_valid` gaps on frame 1 → addresses contiguous with no duplicates, and `img_data_wr_en` count = 784.
3. **Backpressure:** drop `img_data_wr_ready` for 10 cycles at pixel 300 → at most one write after the drop (addr 299 or 300), then a resume at the next address; total 784.
4. **Early `pix_last`:** early `pix_last` at pixel 100 → `frame_err` pulse with the addr-100 write; frame still ends at addr 783 with `work_enable`.
5. **Reset mid-frame:** `rst_n` = 0 for 1 cycle at pixel 500, then a new frame → all outputs 0 the cycle after reset; the new frame starts at addr 0; no `work_enable` for the aborted frame.
6. **Back-to-back frames:** ADDR_BASE = 0x100 with ready always high → second frame's first write at 0x100 no earlier than 2 cycles after the first `work_enable`.
